// File: rtl/osd_char_writer_if.sv
// Command and character-RAM write bundle for osd_char_writer.
// A command transfers on a clk edge where cmd_valid && cmd_ready; cmd_ready is a registered
// IDLE decode, and cmd_op/row/col/data only need to be stable on that edge.
interface osd_char_writer_if #(
    parameter int ADDR_WIDTH = 11
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_op;
    logic [4:0]            cmd_row;
    logic [5:0]            cmd_col;
    logic [15:0]           cmd_data;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [7:0]            wr_data;
    logic                  wr_en;

    modport master (
        output cmd_valid, cmd_op, cmd_row, cmd_col, cmd_data,
        input  cmd_ready, busy, wr_addr, wr_data, wr_en
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_row, cmd_col, cmd_data,
        output cmd_ready, busy, wr_addr, wr_data, wr_en
    );
endinterface

// File: rtl/osd_char_writer.sv
// Turns print commands (PUTC, HEX8/16, DEC12, FILL_ROW, CLEAR) into one OSD char RAM
// write per clock, with column clipping and a 12-cycle double-dabble for decimals.
module osd_char_writer #(
    parameter int         COLS       = 40,
    parameter int         ROWS       = 30,
    parameter int         ADDR_WIDTH = 11,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic               clk,
    input  logic               reset_n,
    osd_char_writer_if.slave   bus,
    output logic [1:0]         dbg_state
);
    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_CONV, S_CLEAR} state_t;

    localparam logic [2:0] OP_PUTC  = 3'd1;
    localparam logic [2:0] OP_HEX8  = 3'd2;
    localparam logic [2:0] OP_HEX16 = 3'd3;
    localparam logic [2:0] OP_DEC12 = 3'd4;
    localparam logic [2:0] OP_FILL  = 3'd5;
    localparam logic [2:0] OP_CLEAR = 3'd6;

    // One spare bit so a full-screen count never overflows the index.
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW:0] COLS_W = (CW+1)'(COLS);
    localparam logic [CW:0] ROWS_W = (CW+1)'(ROWS);

    state_t                state;
    logic                  ready_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [7:0]            wr_data_q;
    logic [2:0]            op_q;
    logic [4:0]            row_q;
    logic [5:0]            col_q;
    logic [15:0]           data_q;
    logic [CW-1:0]         idx;
    logic [CW-1:0]         len_q;
    logic [27:0]           dd;
    logic [27:0]           dd_next;
    logic [3:0]            conv_cnt;

    logic [2:0]            s_op;
    logic [4:0]            s_row;
    logic [5:0]            s_col;
    logic [15:0]           s_val;
    logic [CW-1:0]         s_idx;
    logic [15:0]           hex_src;
    logic [15:0]           hex_sh;
    logic [3:0]            nib;
    logic [5:0]            eff_col;
    logic [CW:0]           col_sum;
    logic [CW:0]           row_ext;
    logic [7:0]            c_char;
    logic                  c_we;
    logic [ADDR_WIDTH-1:0] c_addr;

    function automatic logic [CW-1:0] len_of(input logic [2:0] op);
        case (op)
            OP_PUTC:            len_of = CW'(1);
            OP_HEX8:            len_of = CW'(2);
            OP_HEX16, OP_DEC12: len_of = CW'(4);
            OP_FILL:            len_of = CW'(COLS);
            OP_CLEAR:           len_of = CW'(COLS * ROWS);
            default:            len_of = '0;
        endcase
    endfunction

    // Double-dabble step: BCD digits live in dd[27:12], the binary value shifts out of dd[11:0].
    always_comb begin
        dd_next = dd;
        for (int d = 0; d < 4; d++) begin
            if (dd[12+4*d +: 4] >= 4'd5) dd_next[12+4*d +: 4] = dd[12+4*d +: 4] + 4'd3;
        end
        dd_next = {dd_next[26:0], 1'b0};
    end

    // Character generator: in IDLE it works on the live command so the first write can be
    // registered on the acceptance edge; otherwise it works on the latched command.
    always_comb begin
        s_op    = (state == S_IDLE) ? bus.cmd_op  : op_q;
        s_row   = (state == S_IDLE) ? bus.cmd_row : row_q;
        s_col   = (state == S_IDLE) ? bus.cmd_col : col_q;
        s_idx   = (state == S_IDLE || state == S_CONV) ? '0 : idx;
        s_val   = data_q;
        if (state == S_IDLE)          s_val = bus.cmd_data;
        else if (op_q == OP_DEC12)    s_val = (state == S_CONV) ? dd_next[27:12] : dd[27:12];
        hex_src = (s_op == OP_HEX8) ? {s_val[7:0], 8'h00} : s_val;
        hex_sh  = hex_src << {s_idx[1:0], 2'b00};
        nib     = hex_sh[15:12];
        case (s_op)
            OP_HEX8, OP_HEX16: c_char = (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
            OP_DEC12:          c_char = 8'h30 + {4'h0, nib};
            OP_CLEAR:          c_char = BLANK_CHAR;
            default:           c_char = s_val[7:0];
        endcase
        eff_col = (s_op == OP_FILL) ? 6'd0 : s_col;
        col_sum = (CW+1)'(eff_col) + (CW+1)'(s_idx);
        row_ext = (CW+1)'(s_row);
        c_we    = (s_op == OP_CLEAR) || ((row_ext < ROWS_W) && (col_sum < COLS_W));
        c_addr  = (s_op == OP_CLEAR) ? ADDR_WIDTH'(s_idx)
                                     : ADDR_WIDTH'(row_ext * COLS_W + col_sum);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            ready_q   <= 1'b1;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            op_q      <= '0;
            row_q     <= '0;
            col_q     <= '0;
            data_q    <= '0;
            idx       <= '0;
            len_q     <= '0;
            dd        <= '0;
            conv_cnt  <= '0;
        end else begin
            wr_en_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid && ready_q) begin
                        op_q   <= bus.cmd_op;
                        row_q  <= bus.cmd_row;
                        col_q  <= bus.cmd_col;
                        data_q <= bus.cmd_data;
                        len_q  <= len_of(bus.cmd_op);
                        idx    <= CW'(1);
                        case (bus.cmd_op)
                            OP_PUTC, OP_HEX8, OP_HEX16, OP_FILL, OP_CLEAR: begin
                                state     <= (bus.cmd_op == OP_CLEAR) ? S_CLEAR : S_EMIT;
                                ready_q   <= 1'b0;
                                wr_en_q   <= c_we;
                                wr_addr_q <= c_addr;
                                wr_data_q <= c_char;
                            end
                            OP_DEC12: begin
                                state    <= S_CONV;
                                ready_q  <= 1'b0;
                                idx      <= '0;
                                dd       <= {16'h0000, bus.cmd_data[11:0]};
                                conv_cnt <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_CONV: begin
                    dd       <= dd_next;
                    conv_cnt <= conv_cnt + 4'd1;
                    // The last step's result is consumed directly so the first digit has no gap.
                    if (conv_cnt == 4'd11) begin
                        state     <= S_EMIT;
                        idx       <= CW'(1);
                        wr_en_q   <= c_we;
                        wr_addr_q <= c_addr;
                        wr_data_q <= c_char;
                    end
                end
                S_EMIT, S_CLEAR: begin
                    if (idx == len_q) begin
                        state   <= S_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        wr_en_q   <= c_we;
                        wr_addr_q <= c_addr;
                        wr_data_q <= c_char;
                        idx       <= idx + CW'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.busy      = ~ready_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign dbg_state     = state;
endmodule

// File: tb/tb_osd_char_writer.sv
// Bench for osd_char_writer: a reference model pushes expected {addr,data} writes at
// command acceptance; a negedge monitor pops and compares each DUT write.
module tb_osd_char_writer;
    localparam int COLS = 40;
    localparam int ROWS = 30;
    localparam int AW   = 11;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;
    int model_writes = 0;
    logic [AW+7:0] exp_q[$];
    logic [AW+7:0] last_wr = '0;

    osd_char_writer_if #(.ADDR_WIDTH(AW)) bus ();

    osd_char_writer #(
        .COLS(COLS), .ROWS(ROWS), .ADDR_WIDTH(AW), .BLANK_CHAR(8'h20)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset_n && bus.wr_en) begin
            last_wr = {bus.wr_addr, bus.wr_data};
            if (exp_q.size() == 0) check_eq("write_expected", 32'(exp_q.size()), 32'd1);
            else check_eq("write", 32'({bus.wr_addr, bus.wr_data}), 32'(exp_q.pop_front()));
        end
    end

    function automatic logic [7:0] hexc(input logic [3:0] n);
        string digits;
        digits = "0123456789ABCDEF";
        return digits[n];
    endfunction

    function automatic int len_of(input logic [2:0] op);
        case (op)
            3'd1: return 1;
            3'd2: return 2;
            3'd3, 3'd4: return 4;
            3'd5: return COLS;
            3'd6: return COLS * ROWS;
            default: return 0;
        endcase
    endfunction

    task automatic model_cmd(input logic [2:0] op, input logic [4:0] row, input logic [5:0] col,
                             input logic [15:0] data);
        logic [7:0] ch[$];
        int c0, v;
        model_writes = 0;
        c0 = int'(col);
        v  = int'(data[11:0]);
        case (op)
            3'd1: ch.push_back(data[7:0]);
            3'd2: begin ch.push_back(hexc(data[7:4])); ch.push_back(hexc(data[3:0])); end
            3'd3: for (int i = 3; i >= 0; i--) ch.push_back(hexc(4'(data >> (4 * i))));
            3'd4: begin
                ch.push_back(8'(48 + v / 1000));
                ch.push_back(8'(48 + (v / 100) % 10));
                ch.push_back(8'(48 + (v / 10) % 10));
                ch.push_back(8'(48 + v % 10));
            end
            3'd5: begin c0 = 0; for (int i = 0; i < COLS; i++) ch.push_back(data[7:0]); end
            3'd6: begin
                for (int i = 0; i < COLS * ROWS; i++) exp_q.push_back({AW'(i), 8'h20});
                model_writes = COLS * ROWS;
            end
            default: ;
        endcase
        for (int i = 0; i < ch.size(); i++) begin
            if (int'(row) < ROWS && c0 + i < COLS) begin
                exp_q.push_back({AW'(int'(row) * COLS + c0 + i), ch[i]});
                model_writes++;
            end
        end
    endtask

    // Drive until accepted, push the model, then scramble inputs to prove they were latched.
    task automatic send_cmd(input logic [2:0] op, input logic [4:0] row, input logic [5:0] col,
                            input logic [15:0] data);
        int n;
        n = 0;
        @(negedge clk);
        bus.cmd_op = op; bus.cmd_row = row; bus.cmd_col = col; bus.cmd_data = data;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_eq("accept_ready", 32'(bus.cmd_ready), 32'd1);
        model_cmd(op, row, col, data);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'($urandom_range(0, 7));
        bus.cmd_row   = 5'($urandom_range(0, 31));
        bus.cmd_col   = 6'($urandom_range(0, 63));
        bus.cmd_data  = 16'($urandom_range(0, 65535));
    endtask

    task automatic observe(output int lat, output int wr, output int bsy, output int span);
        int first, last;
        lat = 0; wr = 0; bsy = 0; first = 0; last = 0;
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk);
            if (!bus.busy) break;
            bsy++;
            if (bus.wr_en) begin
                wr++;
                if (first == 0) first = n;
                last = n;
            end
        end
        lat  = first;
        span = (wr > 0) ? last - first + 1 : 0;
    endtask

    task automatic run_cmd(input string name, input logic [2:0] op, input logic [4:0] row,
                           input logic [5:0] col, input logic [15:0] data);
        int lat, wr, bsy, span;
        send_cmd(op, row, col, data);
        observe(lat, wr, bsy, span);
        check_eq({name, "_busy"}, 32'(bsy), 32'(len_of(op) + ((op == 3'd4) ? 12 : 0)));
        check_eq({name, "_writes"}, 32'(wr), 32'(model_writes));
        if (model_writes > 0) begin
            check_eq({name, "_latency"}, 32'(lat), (op == 3'd4) ? 32'd13 : 32'd1);
            check_eq({name, "_span"}, 32'(span), 32'(wr));
        end
    endtask

    initial begin
        int lat, wr, bsy, span, cnt;
        logic [2:0] rops[4];
        rops = '{3'd1, 3'd2, 3'd3, 3'd4};
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_row = '0; bus.cmd_col = '0; bus.cmd_data = '0;

        // Clock / reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("rst_ready", 32'(bus.cmd_ready), 32'd1);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check_eq("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check_eq("rst_wr_data", 32'(bus.wr_data), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'd0);

        run_cmd("nop0", 3'd0, 5'd1, 6'd1, 16'h0041);
        check_eq("nop0_ready", 32'(bus.cmd_ready), 32'd1);
        run_cmd("putc", 3'd1, 5'd2, 6'd5, 16'h0041);
        check_eq("putc_last", 32'(last_wr), 32'({11'd85, 8'h41}));
        run_cmd("hex8", 3'd2, 5'd3, 6'd10, 16'h003C);
        run_cmd("hex16_clip", 3'd3, 5'd0, 6'd38, 16'hBEEF);
        check_eq("hex16_last", 32'(last_wr), 32'({11'd39, 8'h45}));
        run_cmd("dec4095", 3'd4, 5'd29, 6'd0, 16'h0FFF);
        check_eq("dec4095_last", 32'(last_wr), 32'({11'd1163, 8'h35}));
        run_cmd("dec_hi_bits", 3'd4, 5'd7, 6'd3, 16'hF007);
        run_cmd("fill", 3'd5, 5'd4, 6'd17, 16'h0023);
        run_cmd("row_oob", 3'd1, 5'd30, 6'd0, 16'h0058);
        run_cmd("col_oob", 3'd2, 5'd5, 6'd40, 16'h00AB);
        run_cmd("fill_oob", 3'd5, 5'd31, 6'd0, 16'h0031);
        run_cmd("nop7", 3'd7, 5'd0, 6'd0, 16'h0000);

        for (int i = 0; i < 10; i++) begin
            run_cmd("rand", rops[$urandom_range(0, 3)], 5'($urandom_range(0, 31)),
                    6'($urandom_range(0, 45)), 16'($urandom_range(0, 65535)));
        end

        // CLEAR with a second command held pending behind it
        send_cmd(3'd6, 5'd3, 6'd3, 16'h0000);
        bus.cmd_op = 3'd1; bus.cmd_row = 5'd0; bus.cmd_col = 6'd0; bus.cmd_data = 16'h005A;
        bus.cmd_valid = 1'b1;
        observe(lat, wr, bsy, span);
        check_eq("clear_writes", 32'(wr), 32'd1200);
        check_eq("clear_busy", 32'(bsy), 32'd1200);
        check_eq("clear_span", 32'(span), 32'd1200);
        check_eq("clear_latency", 32'(lat), 32'd1);
        check_eq("clear_then_ready", 32'(bus.cmd_ready), 32'd1);
        model_cmd(3'd1, 5'd0, 6'd0, 16'h005A);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        observe(lat, wr, bsy, span);
        check_eq("stalled_putc_writes", 32'(wr), 32'd1);
        check_eq("stalled_putc_latency", 32'(lat), 32'd1);
        check_eq("stalled_putc_last", 32'(last_wr), 32'({11'd0, 8'h5A}));

        // Reset during the 3rd write of a FILL_ROW
        send_cmd(3'd5, 5'd1, 6'd9, 16'h002A);
        repeat (3) @(negedge clk);
        check_eq("fill3_wr_en", 32'(bus.wr_en), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_wr_en", 32'(bus.wr_en), 32'd0);
        check_eq("async_ready", 32'(bus.cmd_ready), 32'd1);
        check_eq("async_state", 32'(dbg_state), 32'd0);
        check_eq("fill_consumed", 32'(exp_q.size()), 32'd37);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.wr_en) cnt++;
        end
        check_eq("post_rst_writes", 32'(cnt), 32'd0);
        check_eq("post_rst_ready", 32'(bus.cmd_ready), 32'd1);

        run_cmd("after_rst", 3'd3, 5'd10, 6'd36, 16'h1A2F);
        check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
